wb_rram_initiator: RTL

WB_RRAM_INITIATOR -- requirements
Module: wb_rram_initiator

---
 rtl/rram_wb_pkg.sv | 25 ++
 rtl/wb_cmd_fifo.sv | 61 ++++++
 rtl/wb_rram_initiator.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rram_wb_pkg.sv
// Shared types for the RRAM Wishbone initiator: controller states,
// the queued command record and the completion record.
package rram_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } cmd_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/wb_cmd_fifo.sv
// In-order command FIFO. A push is dropped when full and a pop is dropped
// when empty, so a write into an empty FIFO is only visible next cycle.
module wb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/wb_rram_initiator.sv
// Wishbone classic initiator fed by a command FIFO. One bus cycle at a
// time; each cycle completes on ack or on timeout and is reported back
// through a valid/ready completion port.
module wb_rram_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    import rram_wb_pkg::*;

    // Counter value seen in the last permitted BUS cycle.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [7:0]       timeout_cnt;
    logic             ready_en;
    rsp_t             rsp_reg;
    cmd_t             push_cmd;
    cmd_t             head_cmd;
    logic [CMD_W-1:0] head_bits;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;

    assign push_cmd  = '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata, sel: cmd_sel};
    assign head_cmd  = cmd_t'(head_bits);
    assign cmd_ready = ready_en && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty;
    assign rsp_rdata = rsp_reg.rdata;
    assign rsp_err   = rsp_reg.err;

    wb_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (push_cmd),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .pop_data  (head_bits),
        .empty     (fifo_empty)
    );

    // Hold off command acceptance until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Controller: issue the FIFO head, wait for ack or timeout, then hold the completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            timeout_cnt <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
            wbm_sel_o   <= '0;
            rsp_valid   <= 1'b0;
            rsp_reg     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        wbm_cyc_o   <= 1'b1;
                        wbm_stb_o   <= 1'b1;
                        wbm_we_o    <= head_cmd.we;
                        wbm_adr_o   <= head_cmd.addr;
                        wbm_dat_o   <= head_cmd.wdata;
                        wbm_sel_o   <= head_cmd.sel;
                        timeout_cnt <= '0;
                        state       <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wbm_ack_i) begin
                        wbm_cyc_o     <= 1'b0;
                        wbm_stb_o     <= 1'b0;
                        rsp_reg.rdata <= wbm_we_o ? 32'h0 : wbm_dat_i;
                        rsp_reg.err   <= 1'b0;
                        rsp_valid     <= 1'b1;
                        state         <= ST_RESP;
                    end else if (timeout_cnt == TIMEOUT_LAST) begin
                        wbm_cyc_o     <= 1'b0;
                        wbm_stb_o     <= 1'b0;
                        rsp_reg.rdata <= 32'h0;
                        rsp_reg.err   <= 1'b1;
                        rsp_valid     <= 1'b1;
                        state         <= ST_RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
